// File: rtl/rgb_fade_engine.sv
// Multi-channel fade-and-PWM engine: each channel fades INC/HOLD_HIGH/DEC/HOLD_LOW and drives one PWM pin.
// Latency: level_o moves 1 clk after tick_o; pwm_o is registered 1 clk after the counter compare.
// No backpressure: free-running outputs. Define RGB_FADE_GAMMA_EN for a quadratic level-to-duty curve.
module rgb_fade_engine #(
    parameter int                  NUM_CH        = 3,
    parameter int                  LVL_W         = 8,
    parameter int                  STEP_DIV      = 12000,
    parameter int                  LEVEL_STEP    = 1,
    parameter int                  HOLD_TICKS    = 256,
    parameter logic [2*NUM_CH-1:0] CH_INIT_STATE = 6'b11_01_00,
    parameter bit                  ACTIVE_LOW    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    restart,
    output logic [NUM_CH-1:0]       pwm_o,
    output logic [NUM_CH*LVL_W-1:0] level_o,
    output logic                    tick_o
);

    localparam int               PS_W    = $clog2(STEP_DIV);
    localparam int               HC_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [LVL_W-1:0] LVL_MAX = '1;
    localparam logic [LVL_W:0]   STEP_X  = (LVL_W+1)'(LEVEL_STEP);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_INC       = 2'b00,
        ST_HOLD_HIGH = 2'b01,
        ST_DEC       = 2'b10,
        ST_HOLD_LOW  = 2'b11
    } state_e;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic              tick_q, tick_d;
    logic              step;
    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [LVL_W-1:0]  level_q [NUM_CH];
    logic [LVL_W-1:0]  level_d [NUM_CH];
    logic [HC_W-1:0]   hold_q  [NUM_CH];
    logic [HC_W-1:0]   hold_d  [NUM_CH];
    logic [LVL_W-1:0]  duty_q  [NUM_CH];
    logic [LVL_W-1:0]  duty_d  [NUM_CH];
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;

    function automatic state_e init_state(input int ch);
        return state_e'(CH_INIT_STATE[2*ch +: 2]);
    endfunction

    function automatic logic [LVL_W-1:0] init_level(input state_e s);
        return (s == ST_HOLD_HIGH || s == ST_DEC) ? LVL_MAX : '0;
    endfunction

    function automatic logic [LVL_W-1:0] level_to_duty(input logic [LVL_W-1:0] lvl);
`ifdef RGB_FADE_GAMMA_EN
        logic [2*LVL_W-1:0] sq;
        sq = {{LVL_W{1'b0}}, lvl} * {{LVL_W{1'b0}}, lvl};
        // Top level must stay fully on; the square alone would fall just short.
        return (lvl == LVL_MAX) ? LVL_MAX : sq[2*LVL_W-1:LVL_W];
`else
        return lvl;
`endif
    endfunction

    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if (restart) begin
            presc_d = '0;
            tick_d  = 1'b0;
        end else if (en) begin
            tick_d  = (presc_q == PS_LAST);
            presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
        end
    end

    assign step = tick_q & en & ~restart;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            hold_d[i]  = hold_q[i];
            if (restart) begin
                state_d[i] = init_state(i);
                level_d[i] = init_level(init_state(i));
                hold_d[i]  = '0;
            end else if (step) begin
                case (state_q[i])
                    ST_INC: begin
                        if (({1'b0, level_q[i]} + STEP_X) >= {1'b0, LVL_MAX}) begin
                            level_d[i] = LVL_MAX;
                            state_d[i] = ST_HOLD_HIGH;
                            hold_d[i]  = '0;
                        end else begin
                            level_d[i] = level_q[i] + STEP_X[LVL_W-1:0];
                        end
                    end
                    ST_DEC: begin
                        if ({1'b0, level_q[i]} <= STEP_X) begin
                            level_d[i] = '0;
                            state_d[i] = ST_HOLD_LOW;
                            hold_d[i]  = '0;
                        end else begin
                            level_d[i] = level_q[i] - STEP_X[LVL_W-1:0];
                        end
                    end
                    default: begin
                        if (hold_q[i] == HC_LAST) begin
                            hold_d[i]  = '0;
                            state_d[i] = (state_q[i] == ST_HOLD_HIGH) ? ST_DEC : ST_INC;
                        end else begin
                            hold_d[i] = hold_q[i] + HC_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Duty is only sampled at the end of a PWM period so a level change never truncates a pulse.
    always_comb begin
        cnt_d = cnt_q + LVL_W'(1);
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = (cnt_q == LVL_MAX) ? level_to_duty(level_q[i]) : duty_q[i];
            pwm_d[i]  = ((cnt_q < duty_q[i]) | (duty_q[i] == LVL_MAX)) ^ ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            pwm_q   <= {NUM_CH{ACTIVE_LOW}};
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= init_state(i);
                level_q[i] <= init_level(init_state(i));
                hold_q[i]  <= '0;
                duty_q[i]  <= '0;
            end
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
                hold_q[i]  <= hold_d[i];
                duty_q[i]  <= duty_d[i];
            end
        end
    end

    always_comb begin
        level_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            level_o[i*LVL_W +: LVL_W] = level_q[i];
        end
    end

    assign pwm_o  = pwm_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Bench for rgb_fade_engine: tick-by-tick level table, PWM duty during pauses, restart and async reset.
module tb_rgb_fade_engine;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic        restart = 1'b0;
    logic [2:0]  pwm, pwm_al;
    logic [11:0] lvl, lvl_al;
    logic        tick, tick_al;

    int errors = 0;
    int checks = 0;

`ifdef RGB_FADE_GAMMA_EN
    localparam int D5  = 1;
    localparam int D10 = 6;
`else
    localparam int D5  = 5;
    localparam int D10 = 10;
`endif

    typedef struct {
        logic        en;
        int          gap;
        logic [11:0] lvl;
    } vec_t;

    rgb_fade_engine #(
        .NUM_CH(3), .LVL_W(4), .STEP_DIV(4), .LEVEL_STEP(5), .HOLD_TICKS(2),
        .CH_INIT_STATE(6'b11_01_00), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .pwm_o(pwm), .level_o(lvl), .tick_o(tick)
    );

    rgb_fade_engine #(
        .NUM_CH(3), .LVL_W(4), .STEP_DIV(4), .LEVEL_STEP(5), .HOLD_TICKS(2),
        .CH_INIT_STATE(6'b11_01_00), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .pwm_o(pwm_al), .level_o(lvl_al), .tick_o(tick_al)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lv(input int c2, input int c1, input int c0);
        return {4'(c2), 4'(c1), 4'(c0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        while (tick !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pause_measure(input string tag, input logic [11:0] exp_lvl,
                                 input int e0, input int e1, input int e2);
        int hi0, hi1, hi2, frozen_bad, pol_bad;
        hi0 = 0; hi1 = 0; hi2 = 0; frozen_bad = 0; pol_bad = 0;
        en = 1'b0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (lvl !== exp_lvl || tick !== 1'b0) frozen_bad++;
            if (pwm_al !== ~pwm || lvl_al !== lvl) pol_bad++;
            if (c >= 20) begin
                if (pwm[0]) hi0++;
                if (pwm[1]) hi1++;
                if (pwm[2]) hi2++;
            end
        end
        chk({tag, " frozen cycles"}, frozen_bad, 0);
        chk({tag, " polarity cycles"}, pol_bad, 0);
        chk({tag, " ch0 high/16"}, hi0, e0);
        chk({tag, " ch1 high/16"}, hi1, e1);
        chk({tag, " ch2 high/16"}, hi2, e2);
    endtask

    initial begin
        vec_t tbl [12];
        int   n;

        tbl[0]  = '{1'b1, 4, lv(0, 15, 5)};
        tbl[1]  = '{1'b1, 3, lv(0, 15, 10)};
        tbl[2]  = '{1'b1, 3, lv(5, 10, 15)};
        tbl[3]  = '{1'b1, 3, lv(10, 5, 15)};
        tbl[4]  = '{1'b1, 3, lv(15, 0, 15)};
        tbl[5]  = '{1'b1, 3, lv(15, 0, 10)};
        tbl[6]  = '{1'b1, 3, lv(15, 0, 5)};
        tbl[7]  = '{1'b1, 3, lv(10, 5, 0)};
        tbl[8]  = '{1'b1, 3, lv(5, 10, 0)};
        tbl[9]  = '{1'b1, 3, lv(0, 15, 0)};
        tbl[10] = '{1'b1, 3, lv(0, 15, 5)};
        tbl[11] = '{1'b1, 3, lv(0, 15, 10)};

        #12;
        chk("reset pwm_o", pwm, 3'b000);
        chk("reset pwm_o active-low", pwm_al, 3'b111);
        chk("reset tick_o", tick, 1'b0);
        chk("reset level_o", lvl, lv(0, 15, 0));

        @(negedge clk);
        en    = 1'b1;
        rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            en = tbl[r].en;
            wait_tick(12, n);
            chk($sformatf("tick gap before t%0d", r + 1), n, tbl[r].gap);
            @(negedge clk);
            chk($sformatf("level after t%0d", r + 1), lvl, tbl[r].lvl);
            chk($sformatf("tick width t%0d", r + 1), tick, 1'b0);
        end

        pause_measure("pause1", lv(0, 15, 10), D10, 16, 0);
        en = 1'b1;
        wait_tick(12, n);
        chk("resume remaining count", n, 3);
        @(negedge clk);
        chk("level after resume tick", lvl, lv(5, 10, 15));

        pause_measure("pause2", lv(5, 10, 15), 16, D10, D5);
        en = 1'b1;
        wait_tick(12, n);
        chk("tick before restart", n, 3);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart level_o", lvl, lv(0, 15, 0));
        chk("restart tick_o", tick, 1'b0);
        wait_tick(12, n);
        chk("first tick after restart", n, 4);
        @(negedge clk);
        chk("level after restart tick", lvl, lv(0, 15, 5));

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset level_o", lvl, lv(0, 15, 0));
        chk("async reset tick_o", tick, 1'b0);
        chk("async reset pwm_o", pwm, 3'b000);
        chk("async reset pwm_o active-low", pwm_al, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
